// File: rtl/wallace_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wallace_arbiter (with helper wallace_mul4)
// Brief    : Two-requester arbiter sharing one 4x4 Wallace-tree multiplier.
//            Define WALLACE_ARB_RR_EN for round-robin grant; default build is
//            fixed priority with requester 0 winning.
// Revision : 1.0  initial release
// ============================================================================

module wallace_mul4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    // pp[i][j] = a[j] & b[i], column weight i+j
    logic [3:0][3:0] pp;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_pp
            assign pp[i] = a & {4{b[i]}};
        end
    endgenerate

    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (z & (x ^ y)), x ^ y ^ z};
    endfunction

    logic w_h1a_s, w_h1a_c, w_h1b_s, w_h1b_c;
    logic w_f2_s, w_f2_c, w_f3_s, w_f3_c, w_f4_s, w_f4_c, w_f5_s, w_f5_c;
    logic [7:0] w_row_x, w_row_y;

    // First layer trims columns 3 and 4 to height three.
    assign {w_h1a_c, w_h1a_s} = ha(pp[0][3], pp[1][2]);
    assign {w_h1b_c, w_h1b_s} = ha(pp[1][3], pp[2][2]);

    // Second layer brings every column down to two rows.
    assign {w_f2_c, w_f2_s} = fa(pp[0][2], pp[1][1], pp[2][0]);
    assign {w_f3_c, w_f3_s} = fa(w_h1a_s, pp[2][1], pp[3][0]);
    assign {w_f4_c, w_f4_s} = fa(w_h1b_s, pp[3][1], w_h1a_c);
    assign {w_f5_c, w_f5_s} = fa(pp[2][3], pp[3][2], w_h1b_c);

    assign w_row_x = {1'b0, pp[3][3], w_f5_s, w_f4_s, w_f3_s, w_f2_s, pp[0][1], pp[0][0]};
    assign w_row_y = {1'b0, w_f5_c, w_f4_c, w_f3_c, w_f2_c, 1'b0, pp[1][0], 1'b0};
    assign p       = w_row_x + w_row_y;
endmodule

module wallace_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_prod,
    output logic       busy,
    output logic [7:0] done_cnt
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     r_state, w_next;
    logic       w_pick0, w_pick1;
    logic       w_grant0, w_grant1, w_accept;
    logic [3:0] r_a, r_b;
    logic       r_id;
    logic [7:0] w_prod;
    logic       r_rsp_valid, r_rsp_id;
    logic [7:0] r_rsp_prod, r_done_cnt;

`ifdef WALLACE_ARB_RR_EN
    // r_last = 1 means requester 1 won last, so requester 0 wins next tie.
    logic r_last;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last <= 1'b1;
        else if (w_accept)
            r_last <= w_grant1;
    end
    assign w_pick0 = req0_valid && (!req1_valid || r_last);
`else
    assign w_pick0 = req0_valid;
`endif
    assign w_pick1 = req1_valid && !w_pick0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Grants are qualified by rst_n so ready stays low throughout reset.
    always_comb begin
        w_next   = r_state;
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        case (r_state)
            IDLE: begin
                w_grant0 = w_pick0 && rst_n;
                w_grant1 = w_pick1 && rst_n;
                if (w_grant0 || w_grant1)
                    w_next = MUL;
            end
            MUL:  w_next = HOLD;
            HOLD: if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    assign w_accept = w_grant0 | w_grant1;

    wallace_mul4 u_mul (
        .a (r_a),
        .b (r_b),
        .p (w_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= 4'd0;
            r_b         <= 4'd0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_prod  <= 8'd0;
            r_done_cnt  <= 8'd0;
        end else begin
            if (w_accept) begin
                r_a  <= w_grant1 ? req1_a : req0_a;
                r_b  <= w_grant1 ? req1_b : req0_b;
                r_id <= w_grant1;
            end
            if (r_state == MUL) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_id;
                r_rsp_prod  <= w_prod;
            end
            if (r_state == HOLD && rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_done_cnt  <= r_done_cnt + 8'd1;
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_prod   = r_rsp_prod;
    assign busy       = (r_state != IDLE);
    assign done_cnt   = r_done_cnt;
endmodule
`default_nettype wire

// File: tb/tb_wallace_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wallace_arbiter
// Brief    : Scoreboard bench for wallace_arbiter: reference model predicts
//            grants/timing, monitor compares each presented response.
// Revision : 1.0  initial release
// ============================================================================
module tb_wallace_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
    logic [3:0] req0_a = 4'd0, req0_b = 4'd0, req1_a = 4'd0, req1_b = 4'd0;
    logic       req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [7:0] rsp_prod, done_cnt;

    wallace_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_prod   (rsp_prod),
        .busy       (busy),
        .done_cnt   (done_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       id;
        logic [7:0] prod;
    } rsp_t;
    rsp_t sb_q[$];

    // Reference model state: one transaction in flight at most.
    bit         m_pend = 1'b0;
    int         m_cyc = 0;
    int         m_resp_from = 0;
    logic [7:0] m_done = 8'd0;
    bit         acc0 = 1'b0, acc1 = 1'b0;
`ifdef WALLACE_ARB_RR_EN
    bit         m_last = 1'b1;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit   e0, e1, ev;
        rsp_t r;
        if (!rst_n) begin
            m_pend = 1'b0;
            m_done = 8'd0;
            acc0   = 1'b0;
            acc1   = 1'b0;
`ifdef WALLACE_ARB_RR_EN
            m_last = 1'b1;
`endif
            sb_q.delete();
        end else begin
            m_cyc++;
            ev = m_pend && (m_cyc >= m_resp_from);
            chk("busy", 32'(busy), 32'(m_pend));
            chk("rsp_valid", 32'(rsp_valid), 32'(ev));
            chk("done_cnt", 32'(done_cnt), 32'(m_done));
            e0 = 1'b0;
            e1 = 1'b0;
            if (!m_pend) begin
                if (req0_valid && req1_valid) begin
`ifdef WALLACE_ARB_RR_EN
                    if (m_last) e0 = 1'b1; else e1 = 1'b1;
`else
                    e0 = 1'b1;
`endif
                end else begin
                    e0 = req0_valid;
                    e1 = req1_valid;
                end
            end
            chk("req0_ready", 32'(req0_ready), 32'(e0));
            chk("req1_ready", 32'(req1_ready), 32'(e1));
            acc0 = e0;
            acc1 = e1;
            if (e0 || e1) begin
                r.id   = e1;
                r.prod = e1 ? 8'(req1_a) * 8'(req1_b) : 8'(req0_a) * 8'(req0_b);
                sb_q.push_back(r);
                m_pend      = 1'b1;
                m_resp_from = m_cyc + 2;
`ifdef WALLACE_ARB_RR_EN
                m_last = e1;
`endif
            end else if (ev && rsp_ready) begin
                m_pend = 1'b0;
                m_done = m_done + 8'd1;
            end
        end
    end

    // Monitor: every cycle a response is presented it must match the queue head.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual=id%0d/%0d expected=none at %0t",
                         rsp_id, rsp_prod, $time);
            end else begin
                chk("rsp_id", 32'(rsp_id), 32'(sb_q[0].id));
                chk("rsp_prod", 32'(rsp_prod), 32'(sb_q[0].prod));
                if (rsp_ready) void'(sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop(input bit id);
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic issue(input bit id, input logic [3:0] a, input logic [3:0] b);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            if ((id && acc1) || (!id && acc0)) begin
                drop(id);
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL issue_timeout actual=not_accepted expected=accepted req%0d", id);
        drop(id);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {8'd0, req0_ready, req1_ready, rsp_valid, rsp_id, busy, 3'd0, rsp_prod, done_cnt},
            32'd0);
    endtask

    initial begin
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (3) tick();
        chk_reset_outputs("reset_state");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b1;
        tick();
        rsp_ready = 1'b1;

        issue(1'b0, 4'd7, 4'd9);
        repeat (4) tick();
        issue(1'b1, 4'd15, 4'd15);
        repeat (4) tick();

        // Continuous contention: RR alternates, fixed priority starves req1.
        req0_a = 4'd3; req0_b = 4'd4; req1_a = 4'd5; req1_b = 4'd6;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (12) tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (4) tick();

        // Backpressure with a competing request waiting.
        rsp_ready = 1'b0;
        issue(1'b0, 4'd2, 4'd13);
        req1_valid = 1'b1; req1_a = 4'd11; req1_b = 4'd12;
        repeat (12) tick();
        rsp_ready = 1'b1;
        issue(1'b1, 4'd11, 4'd12);
        repeat (4) tick();

        // Reset while the 9*9 transaction sits in MUL.
        issue(1'b0, 4'd9, 4'd9);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        repeat (2) tick();
        chk_reset_outputs("mid_reset_hold");
        rst_n = 1'b1;
        repeat (6) tick();

        for (int n = 0; n < 256; n++)
            issue(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        repeat (3) tick();
        chk("done_wrap", 32'(done_cnt), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            if (acc0) req0_valid = 1'b0;
            if (acc1) req1_valid = 1'b0;
            if (!req0_valid) begin
                req0_a     = 4'($urandom_range(0, 15));
                req0_b     = 4'($urandom_range(0, 15));
                req0_valid = ($urandom_range(0, 2) == 0);
            end
            if (!req1_valid) begin
                req1_a     = 4'($urandom_range(0, 15));
                req1_b     = 4'($urandom_range(0, 15));
                req1_valid = ($urandom_range(0, 2) == 0);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        repeat (10) tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wallace_arbiter.md
WALLACE_ARBITER -- requirements
Module: wallace_arbiter

Interface
REQ-001 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_a, req0_b  input  4 each  requester 0 operands, unsigned.
- req0_ready  output  1  requester 0 operands accepted this cycle.
- req1_valid  input  1  requester 1 has an operand pair.
- req1_a, req1_b  input  4 each  requester 1 operands, unsigned.
- req1_ready  output  1  requester 1 operands accepted this cycle.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  1  requester index that owns rsp_prod.
- rsp_prod  output  8  unsigned product.
- busy  output  1  high in any state other than IDLE.
- done_cnt  output  8  count of completed result handshakes.
REQ-002 The block SHALL contain exactly one internal 4x4 Wallace-tree multiplier instance, shared by both requesters.

Function
REQ-003 The FSM SHALL have three states: IDLE, MUL, HOLD.
REQ-004 In IDLE with at least one reqN_valid high, the block SHALL grant one requester, pulse its reqN_ready high for that cycle only, latch its a/b and index, and enter MUL on the next edge.
REQ-005 A requester SHALL be considered accepted only in a cycle where reqN_valid and reqN_ready are both high; the ready signals SHALL never both be high at once.
REQ-006 In IDLE with no reqN_valid high, the block SHALL remain in IDLE with both ready signals low.
REQ-007 In MUL, the block SHALL drive the latched operands into the multiplier, register its 8-bit output into rsp_prod, set rsp_valid, and enter HOLD; latency from acceptance edge to rsp_valid high SHALL be exactly 2 clocks.
REQ-008 rsp_prod SHALL equal a*b, full 8-bit width, with no truncation (max 15*15=225).
REQ-009 In HOLD, rsp_valid, rsp_id and rsp_prod SHALL remain stable until rsp_ready is high; on that edge rsp_valid SHALL clear, done_cnt SHALL increment, and the FSM SHALL return to IDLE.
REQ-010 done_cnt SHALL wrap from 255 to 0.
REQ-011 No new request SHALL be accepted in MUL or HOLD; requesters SHALL hold valid and operands until their ready pulse; minimum issue interval SHALL be 3 clocks.
REQ-012 Changes on reqN inputs during MUL or HOLD SHALL NOT affect the in-flight result.

Reset
REQ-013 While rst_n is low, the FSM SHALL be IDLE and rsp_valid, rsp_id, rsp_prod, req0_ready, req1_ready, busy and done_cnt SHALL all be 0, independent of clk.
REQ-014 Reset asserted in MUL or HOLD SHALL discard the in-flight transaction without producing a response.
REQ-015 The round-robin last-grant register, when present, SHALL reset to 1, so requester 0 wins the first contention.

Configuration
REQ-016 With macro WALLACE_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the requester not granted last wins, and the last-grant register updates on every acceptance.
REQ-017 Without WALLACE_ARB_RR_EN, simultaneous requests SHALL be granted by fixed priority, requester 0 always winning, and no last-grant register SHALL exist.

Verification
REQ-018 Single request: req0 a=7, b=9, rsp_ready held high -> req0_ready pulses one cycle; 2 clocks later rsp_valid=1, rsp_prod=63, rsp_id=0; done_cnt=1.
REQ-019 Maximum operands: req1 a=15, b=15 -> rsp_prod=225, rsp_id=1.
REQ-020 Contention with WALLACE_ARB_RR_EN: both valid continuously, req0 3*4 and req1 5*6 -> responses alternate: 12 (id 0), 30 (id 1), 12 (id 0); without the macro -> 12 (id 0) repeated and req1 starved.
REQ-021 Backpressure: rsp_ready low for 10 cycles after rsp_valid with 2*13 -> rsp_prod stays 26, req ready signals stay low; rsp_ready high -> IDLE next cycle.
REQ-022 Reset mid-operation: assert rst_n low during MUL after accepting 9*9 -> all outputs 0 immediately; after release, no response for 81 appears and done_cnt=0.
REQ-023 Wrap: 256 completed transactions -> done_cnt returns to 0.
